// File: rtl/dist_fifo_pkg.sv
// Shared constants for the distributed-RAM synchronous FIFO: legal parameter
// ranges and the pointer-width helper (address bits plus one wrap bit).
package dist_fifo_pkg;

  localparam int DATA_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MAX = 256;
  localparam int ADDR_WIDTH_MIN = 4;
  localparam int ADDR_WIDTH_MAX = 10;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/dist_sync_sdpram.sv
// Single-clock simple dual-port distributed RAM: synchronous write, asynchronous
// read, no reset on the array.
module dist_sync_sdpram
  import dist_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dist_sync_fifo.sv
// Synchronous FIFO on distributed RAM with registered occupancy/status flags and
// optional first-word-fall-through. Define DIST_SYNC_FIFO_ERR_FLAG_EN for sticky
// overflow/underflow flags; otherwise those ports are tied low.
module dist_sync_fifo
  import dist_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_width(ADDR_WIDTH);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_param
    $error("dist_sync_fifo: DATA_WIDTH or ADDR_WIDTH outside legal range");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_acc     = wr_en & ~full;
  assign rd_acc     = rd_en & ~empty;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_acc);
  // Modular subtraction of the wrap-bit pointers yields 0..DEPTH directly.
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      full         <= (wr_ptr_nxt ^ rd_ptr_nxt) == {1'b1, {ADDR_WIDTH{1'b0}}};
      empty        <= wr_ptr_nxt == rd_ptr_nxt;
      almost_full  <= count_nxt >= PW'(AF_LEVEL);
      almost_empty <= count_nxt <= PW'(AE_LEVEL);
    end
  end

  dist_sync_sdpram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign rd_data = ram_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (!rst_n)      rd_q <= '0;
      else if (rd_acc) rd_q <= ram_rdata;
    end
    assign rd_data = rd_q;
  end

`ifdef DIST_SYNC_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
